// File: rtl/int2flt_pkg.sv
// int2flt_pkg: shared FSM encoding and half-precision field constants
package int2flt_pkg;
  typedef enum logic [3:0] {IDLE, ARMED, RD_LO, RD_HI, NORM, ROUND, WR_LO, WR_HI, DONE} state_t;
  localparam int BIAS = 15;
  localparam int EXP_W = 5;
  localparam int MANT_W = 10;
  localparam int EXP_TOP = BIAS + 15;
endpackage

// File: rtl/int2flt_ref_dat_mem.sv
// dat_mem: single-port data memory, combinational read, posedge write
module dat_mem #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_core [2**AW];
  always_ff @(posedge clk)
    if (we) mem_core[addr] <= wdata;
  assign rdata = mem_core[addr];
endmodule

// File: rtl/int2flt_ref.sv
// int2flt_ref: converts a 16-bit signed integer in memory to an IEEE half float in memory
module int2flt_ref
  import int2flt_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8,
  parameter int IN_ADDR = 0,
  parameter int OUT_ADDR = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);
  state_t state, next;
  logic [DW-1:0] lo, rdata, wdata;
  logic [AW-1:0] addr;
  logic we, sign, shift, rnd;
  logic [15:0] x, mag, res;
  logic [3:0] k;
  logic [EXP_W-1:0] ex;

  dat_mem #(.DW(DW), .AW(AW)) dm1 (.clk(clk), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata));

  assign x = {rdata, lo};
  assign shift = !mag[15] && mag != 16'd0;
  assign ex = EXP_W'(EXP_TOP) - EXP_W'(k);
  assign rnd = mag[4] & ((|mag[3:0]) | mag[5]);

  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= next;

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  next = start ? ARMED : IDLE;
      ARMED: next = start ? ARMED : RD_LO;
      RD_LO: next = RD_HI;
      RD_HI: next = NORM;
      NORM:  next = shift ? NORM : ROUND;
      ROUND: next = WR_LO;
      WR_LO: next = WR_HI;
      WR_HI: next = DONE;
      DONE:  next = start ? ARMED : DONE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      lo <= '0;
      sign <= 1'b0;
      mag <= '0;
      k <= '0;
      res <= '0;
    end else begin
      if (state == RD_LO) lo <= rdata;
      if (state == RD_HI) begin
        sign <= x[15];
        mag <= x[15] ? -x : x;
        k <= '0;
      end
      if (state == NORM && shift) begin
        mag <= mag << 1;
        k <= k + 4'd1;
      end
      // the 15-bit add lets a mantissa overflow carry straight into the exponent
      if (state == ROUND)
        res <= mag == 16'd0 ? 16'd0 : {sign, {ex, mag[14:5]} + (EXP_W+MANT_W)'(rnd)};
    end

  always_comb begin
    we = state == WR_LO || state == WR_HI;
    addr = state == RD_HI ? AW'(IN_ADDR + 1) :
           state == WR_LO ? AW'(OUT_ADDR) :
           state == WR_HI ? AW'(OUT_ADDR + 1) : AW'(IN_ADDR);
    wdata = state == WR_HI ? res[15:8] : res[7:0];
    done = state == DONE;
  end
endmodule

// File: tb/tb_int2flt_ref.sv
// tb_int2flt_ref: scoreboard bench comparing memory results and latency against a rounding model
module tb_int2flt_ref;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic done;
  int n_tests = 0, n_fail = 0;
  typedef struct {logic [15:0] res; int lat;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  int2flt_ref dut (.clk(clk), .reset(reset), .start(start), .done(done));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // rounds by shifting right from the top set bit, independent of the normalizer
  function automatic exp_t model(input logic [15:0] x);
    exp_t e;
    logic [15:0] mag;
    int p, q, rem, half, sh;
    mag = x[15] ? 16'(-x) : x;
    if (mag == 16'd0) begin
      e.res = 16'h0000;
      e.lat = 6;
      return e;
    end
    p = 15;
    while (!mag[p]) p--;
    e.lat = 6 + (15 - p);
    if (p <= 10) q = int'(mag) << (10 - p);
    else begin
      sh = p - 10;
      q = int'(mag) >> sh;
      rem = int'(mag) & ((1 << sh) - 1);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && q % 2 == 1)) q++;
      if (q == 2048) begin
        q = 1024;
        p++;
      end
    end
    e.res = {x[15], 5'(p + 15), 10'(q)};
    return e;
  endfunction

  task automatic run_case(input logic [15:0] x, input int hold);
    exp_t e;
    int cnt;
    @(negedge clk);
    start = 1'b1;
    dut.dm1.mem_core[0] = x[7:0];
    dut.dm1.mem_core[1] = x[15:8];
    sb.push_back(model(x));
    @(posedge clk);
    #1 check("done_drop", done, 0);
    repeat (hold - 1) @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    cnt = 0;
    while (cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
      if (done) break;
    end
    e = sb.pop_front();
    check($sformatf("lat_%h", x), cnt, e.lat);
    check($sformatf("res_%h", x), {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, e.res);
  endtask

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    check("reset_done", done, 0);
    reset = 1'b0;
    run_case(16'h0000, 1);
    check("zero_direct", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h0000);
    run_case(16'h0001, 1);
    check("one_direct", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h3C00);
    run_case(16'hFFFF, 1);
    run_case(16'h7FFF, 1);
    check("max_direct", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h7800);
    run_case(16'h8000, 1);
    run_case(16'h0801, 1);
    check("tie_even", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h6800);
    run_case(16'h0803, 1);
    check("tie_odd", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h6802);
    dut.dm1.mem_core[2] = 8'hA5;
    dut.dm1.mem_core[3] = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    dut.dm1.mem_core[0] = 8'h01;
    dut.dm1.mem_core[1] = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= done;
    end
    check("abort_done", seen, 0);
    check("abort_mem", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h5AA5);
    run_case(16'h0002, 1);
    check("after_abort", {dut.dm1.mem_core[3], dut.dm1.mem_core[2]}, 16'h4000);
    run_case(16'h1234, 3);
    run_case(16'hC000, 3);
    for (int i = 0; i < 10; i++) run_case(16'($urandom), 1 + i % 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
